hit_detector: RTL and testbench

HIT_DETECTOR -- requirements
Module: hit_detector

---
 rtl/hit_detector.sv | 115 +++++++++++
 tb/tb_hit_detector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hit_detector.sv
// Whack-a-mole hit detector: synchronizes and debounces the hole buttons,
// then classifies each fresh press as a hit or a miss against the shown mole.
module hit_detector #(
   parameter int NUM_HOLES       = 9,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 mole_valid,
   input  logic [3:0]           mole_pos,
   input  logic [NUM_HOLES-1:0] btn,
   output logic                 score_trigger,
   output logic                 mole_hit,
   output logic                 miss_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [4:0] HOLES = 5'(NUM_HOLES);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      LOCKOUT
   } state_t;

   logic [NUM_HOLES-1:0] sync1;
   logic [NUM_HOLES-1:0] s;
   logic [NUM_HOLES-1:0] db;
   logic [NUM_HOLES-1:0] db_q;
   logic [CW-1:0]        cnt [NUM_HOLES];

   logic [NUM_HOLES-1:0] press;
   logic [NUM_HOLES-1:0] sel;
   logic                 mole_ok;
   logic                 hit;

   state_t state, state_n;
   logic   hit_n, miss_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         s     <= '0;
         db    <= '0;
         db_q  <= '0;
         for (int i = 0; i < NUM_HOLES; i++) cnt[i] <= '0;
      end else begin
         sync1 <= btn;
         s     <= sync1;
         db_q  <= db;
         // db flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample
         for (int i = 0; i < NUM_HOLES; i++) begin
            if (s[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               cnt[i] <= '0;
               db[i]  <= ~db[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign press   = db & ~db_q;
   assign mole_ok = mole_valid && ({1'b0, mole_pos} < HOLES);

   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_HOLES; i++) begin
         if (mole_pos == i[3:0]) sel[i] = 1'b1;
      end
   end

   assign hit = mole_ok && (|(press & sel));

   always_comb begin
      state_n = state;
      hit_n   = 1'b0;
      miss_n  = 1'b0;
      if (!enable) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: state_n = (|db) ? LOCKOUT : ARMED;
            ARMED: begin
               if (|press) begin
                  state_n = LOCKOUT;
                  hit_n   = hit;
                  miss_n  = ~hit;
               end
            end
            LOCKOUT: if (db == '0) state_n = ARMED;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         score_trigger <= 1'b0;
         mole_hit      <= 1'b0;
         miss_pulse    <= 1'b0;
      end else begin
         state         <= state_n;
         score_trigger <= hit_n;
         mole_hit      <= hit_n;
         miss_pulse    <= miss_n;
      end
   end

endmodule

// File: tb/tb_hit_detector.sv
// Directed bench for hit_detector: latency, hit/miss, bounce, lockout,
// enable and reset behaviour with hand-computed expectations.
module tb_hit_detector;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       mole_valid;
   logic [3:0] mole_pos;
   logic [8:0] btn;
   logic       score_trigger;
   logic       mole_hit;
   logic       miss_pulse;

   int errors = 0;
   int checks = 0;
   int n_score = 0;
   int n_hit = 0;
   int n_miss = 0;
   int n_both = 0;
   int n_diff = 0;
   int s0, m0;

   hit_detector #(.NUM_HOLES(9), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .mole_valid(mole_valid),
      .mole_pos(mole_pos),
      .btn(btn),
      .score_trigger(score_trigger),
      .mole_hit(mole_hit),
      .miss_pulse(miss_pulse)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (score_trigger) n_score++;
      if (mole_hit) n_hit++;
      if (miss_pulse) n_miss++;
      if (score_trigger && miss_pulse) n_both++;
      if (score_trigger != mole_hit) n_diff++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s0 = n_score;
      m0 = n_miss;
   endtask

   task automatic expect_delta(input string tag, input int ds, input int dm);
      check({tag, "_score"}, n_score - s0, ds);
      check({tag, "_miss"}, n_miss - m0, dm);
   endtask

   task automatic press(input logic [8:0] mask, input int hold);
      btn = mask;
      tick(hold);
      btn = '0;
      tick(20);
   endtask

   initial begin
      rst = 1'b1;
      enable = 1'b0;
      mole_valid = 1'b0;
      mole_pos = 4'd0;
      btn = '0;
      tick(3);
      check("rst_score", int'(score_trigger), 0);
      check("rst_hit", int'(mole_hit), 0);
      check("rst_miss", int'(miss_pulse), 0);

      rst = 1'b0;
      enable = 1'b1;
      mole_valid = 1'b1;
      mole_pos = 4'd3;
      tick(3);

      snap();
      btn = 9'b0_0000_1000;
      tick(6);
      check("lat_e6_score", int'(score_trigger), 0);
      tick(1);
      check("lat_e7_score", int'(score_trigger), 1);
      check("lat_e7_hit", int'(mole_hit), 1);
      check("lat_e7_miss", int'(miss_pulse), 0);
      tick(1);
      check("lat_e8_score", int'(score_trigger), 0);
      tick(2);
      btn = '0;
      tick(20);
      expect_delta("hit", 1, 0);

      snap();
      btn = 9'b0_0010_0000;
      tick(7);
      check("miss_e7", int'(miss_pulse), 1);
      tick(3);
      btn = '0;
      tick(20);
      expect_delta("miss", 0, 1);

      snap();
      press(9'b0_0010_1000, 10);
      expect_delta("prio", 1, 0);

      snap();
      for (int k = 0; k < 5; k++) begin
         btn = 9'b0_0000_1000;
         tick(2);
         btn = '0;
         tick(2);
      end
      tick(15);
      expect_delta("bounce", 0, 0);
      snap();
      press(9'b0_0000_1000, 10);
      expect_delta("bounce_hold", 1, 0);

      snap();
      btn = 9'b0_0000_1000;
      tick(20);
      expect_delta("lock_first", 1, 0);
      snap();
      mole_pos = 4'd4;
      tick(10);
      btn = 9'b0_0001_1000;
      tick(20);
      btn = '0;
      tick(20);
      expect_delta("lock_hold", 0, 0);
      snap();
      press(9'b0_0001_0000, 10);
      expect_delta("lock_after", 1, 0);

      mole_pos = 4'd3;
      enable = 1'b0;
      tick(2);
      snap();
      btn = 9'b0_0000_1000;
      tick(12);
      enable = 1'b1;
      tick(15);
      expect_delta("en_held", 0, 0);
      btn = '0;
      tick(20);
      snap();
      press(9'b0_0000_1000, 10);
      expect_delta("en_repress", 1, 0);

      snap();
      btn = 9'b0_0000_1000;
      tick(4);
      rst = 1'b1;
      tick(1);
      check("rstmid_score", int'(score_trigger), 0);
      check("rstmid_miss", int'(miss_pulse), 0);
      tick(1);
      rst = 1'b0;
      tick(6);
      check("rstmid_e6", n_score - s0, 0);
      check("rstmid_e6_out", int'(score_trigger), 0);
      tick(1);
      check("rstmid_e7", int'(score_trigger), 1);
      tick(3);
      btn = '0;
      tick(20);
      expect_delta("rstmid", 1, 0);

      snap();
      mole_pos = 4'd12;
      press(9'b0_0000_0001, 10);
      expect_delta("range", 0, 1);
      snap();
      mole_pos = 4'd3;
      mole_valid = 1'b0;
      press(9'b0_0000_1000, 10);
      expect_delta("novalid", 0, 1);

      check("never_both", n_both, 0);
      check("hit_eq_score", n_diff, 0);
      check("hit_count", n_hit, n_score);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
